// File: rtl/qspi_flash_ctrl.sv
// Config-flash arbiter: passes the external SPI master straight through, or runs one
// internal command (opcode, optional 24-bit address, 0-4 TX bytes, 0-4 RX bytes) in SPI mode 0.
module qspi_flash_ctrl #(
  parameter int G_CLKDIV   = 2,
  parameter int G_CS_SETUP = 2,
  parameter int G_CS_HOLD  = 2,
  parameter int G_CS_GAP   = 4,
  parameter int G_EXT_IDLE = 8
) (
  input  logic        p_in_clk,
  input  logic        p_in_rst,
  input  logic        p_in_start,
  input  logic [7:0]  p_in_opcode,
  input  logic [23:0] p_in_addr,
  input  logic        p_in_addr_en,
  input  logic [31:0] p_in_tx_data,
  input  logic [2:0]  p_in_tx_cnt,
  input  logic [2:0]  p_in_rx_cnt,
  output logic [31:0] p_out_rx_data,
  output logic        p_out_busy,
  output logic        p_out_done,
  output logic        p_out_err_coll,
  input  logic        p_in_err_clr,
  input  logic        p_in_ext_cs,
  input  logic        p_in_ext_sck,
  input  logic        p_in_ext_mosi,
  output logic        p_out_ext_miso,
  output logic        p_out_qspi_cs,
  output logic        p_out_qspi_sck,
  output logic        p_out_qspi_mosi,
  input  logic        p_in_qspi_miso
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUS, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam int IDLE_W = $clog2(G_EXT_IDLE + 1) + 1;
  localparam logic [IDLE_W-1:0] IDLE_MIN   = IDLE_W'(G_EXT_IDLE);
  localparam logic [15:0]       SETUP_LAST = 16'(G_CS_SETUP - 1);
  localparam logic [15:0]       HOLD_LAST  = 16'(G_CS_HOLD - 1);
  localparam logic [15:0]       GAP_LAST   = 16'(G_CS_GAP - 1);
  localparam logic [15:0]       DIV_LAST   = 16'(G_CLKDIV - 1);

  state_t             state_reg;
  logic               owner_int_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_coll_reg;
  logic               cs_reg;
  logic               sck_reg;
  logic               mosi_reg;
  logic [31:0]        rx_data_reg;
  logic [95:0]        frame_reg;
  logic [6:0]         nbits_reg;
  logic [6:0]         rx_start_reg;
  logic [6:0]         bit_idx_reg;
  logic [15:0]        tmr_reg;
  logic               cs_meta_reg;
  logic               cs_sync_reg;
  logic [IDLE_W-1:0]  idle_cnt_reg;

  logic [2:0]  tx_n;
  logic [2:0]  rx_n;
  logic [31:0] tx_masked;
  logic [95:0] frame_next;
  logic [6:0]  nbits_next;

  // Command frame is left-aligned: opcode, address, TX bytes taken from tx_data[31:24]
  // downwards, then zeros so MOSI stays low through the RX bytes.
  always_comb begin
    tx_n       = (p_in_tx_cnt > 3'd4) ? 3'd4 : p_in_tx_cnt;
    rx_n       = (p_in_rx_cnt > 3'd4) ? 3'd4 : p_in_rx_cnt;
    tx_masked  = p_in_tx_data & ~(32'hFFFF_FFFF >> {tx_n, 3'b000});
    frame_next = p_in_addr_en ? {p_in_opcode, p_in_addr, tx_masked, 32'd0}
                              : {p_in_opcode, tx_masked, 56'd0};
    nbits_next = 7'd8 + (p_in_addr_en ? 7'd24 : 7'd0) + {1'b0, tx_n, 3'b000}
                 + {1'b0, rx_n, 3'b000};
  end

  // Synced ext CS resets low so the engine waits for a full idle window after reset.
  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      cs_meta_reg  <= 1'b0;
      cs_sync_reg  <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      cs_meta_reg <= p_in_ext_cs;
      cs_sync_reg <= cs_meta_reg;
      if (!cs_sync_reg)
        idle_cnt_reg <= '0;
      else if (idle_cnt_reg < IDLE_MIN)
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      state_reg     <= S_IDLE;
      owner_int_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_coll_reg  <= 1'b0;
      cs_reg        <= 1'b1;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      rx_data_reg   <= '0;
      frame_reg     <= '0;
      nbits_reg     <= '0;
      rx_start_reg  <= '0;
      bit_idx_reg   <= '0;
      tmr_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (owner_int_reg && !cs_sync_reg)
        err_coll_reg <= 1'b1;
      else if (p_in_err_clr)
        err_coll_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (p_in_start) begin
            frame_reg    <= frame_next;
            nbits_reg    <= nbits_next;
            rx_start_reg <= nbits_next - {1'b0, rx_n, 3'b000};
            rx_data_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= S_WAIT_BUS;
          end
        end
        S_WAIT_BUS: begin
          if (idle_cnt_reg >= IDLE_MIN) begin
            owner_int_reg <= 1'b1;
            cs_reg        <= 1'b0;
            sck_reg       <= 1'b0;
            mosi_reg      <= 1'b0;
            tmr_reg       <= '0;
            state_reg     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_reg == SETUP_LAST) begin
            tmr_reg     <= '0;
            mosi_reg    <= frame_reg[95];
            bit_idx_reg <= '0;
            state_reg   <= S_SHIFT;
          end else begin
            tmr_reg <= tmr_reg + 16'd1;
          end
        end
        S_SHIFT: begin
          if (tmr_reg == DIV_LAST) begin
            tmr_reg <= '0;
            if (!sck_reg) begin
              sck_reg <= 1'b1;
              if (bit_idx_reg >= rx_start_reg)
                rx_data_reg <= {rx_data_reg[30:0], p_in_qspi_miso};
            end else begin
              sck_reg <= 1'b0;
              if (bit_idx_reg == nbits_reg - 7'd1) begin
                mosi_reg  <= 1'b0;
                state_reg <= S_HOLD;
              end else begin
                frame_reg   <= {frame_reg[94:0], 1'b0};
                mosi_reg    <= frame_reg[94];
                bit_idx_reg <= bit_idx_reg + 7'd1;
              end
            end
          end else begin
            tmr_reg <= tmr_reg + 16'd1;
          end
        end
        S_HOLD: begin
          if (tmr_reg == HOLD_LAST) begin
            tmr_reg   <= '0;
            cs_reg    <= 1'b1;
            state_reg <= S_GAP;
          end else begin
            tmr_reg <= tmr_reg + 16'd1;
          end
        end
        S_GAP: begin
          if (tmr_reg == GAP_LAST) begin
            tmr_reg       <= '0;
            owner_int_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= S_IDLE;
          end else begin
            tmr_reg <= tmr_reg + 16'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // External pins pass through combinationally so the ext master sees no added latency.
  assign p_out_qspi_cs   = owner_int_reg ? cs_reg   : p_in_ext_cs;
  assign p_out_qspi_sck  = owner_int_reg ? sck_reg  : p_in_ext_sck;
  assign p_out_qspi_mosi = owner_int_reg ? mosi_reg : p_in_ext_mosi;
  assign p_out_ext_miso  = owner_int_reg ? 1'b1     : p_in_qspi_miso;

  assign p_out_rx_data  = rx_data_reg;
  assign p_out_busy     = busy_reg;
  assign p_out_done     = done_reg;
  assign p_out_err_coll = err_coll_reg;

endmodule
